// File: rtl/uart_write_queue_pkg.sv
// uart_write_queue_pkg: FSM encodings and queue entry layout shared by the write-queue files
package uart_write_queue_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WRITE_WAIT = 2'd1;
  localparam logic [1:0] READ_WAIT = 2'd2;
  typedef struct packed {
    logic [1:0] size;
    logic [31:0] data;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/uart_write_queue_fifo.sv
// fifo_sync: single-clock circular FIFO with occupancy count; contents are not reset, only pointers
module fifo_sync #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rstn,
  input logic push,
  input logic pop,
  input logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_write_queue.sv
// uart_write_queue: queues CPU writes to the UART byte buffer and orders a pending read after them
module uart_write_queue
  import uart_write_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rstn,
  input logic req_wenable,
  input logic [1:0] req_wsize,
  input logic [31:0] req_wdata,
  output logic req_wready,
  input logic req_renable,
  output logic req_rdone,
  output logic [31:0] req_rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic err_overflow,
  output logic wenable,
  output logic [1:0] wsize,
  output logic [31:0] wdata,
  input logic wdone,
  output logic renable,
  input logic rdone,
  input logic [31:0] rdata
);
  logic [1:0] state, next_state;
  logic read_pending, full, empty, push, pop, start_read, write_done, read_done;
  entry_t head;
  assign req_wready = !full && !read_pending;
  assign push = req_wenable && req_wready;
  // queued writes always win over a pending read
  assign pop = state == IDLE && !empty;
  assign start_read = state == IDLE && empty && read_pending;
  assign write_done = state == WRITE_WAIT && wdone;
  assign read_done = state == READ_WAIT && rdone;
  assign next_state = pop ? WRITE_WAIT : start_read ? READ_WAIT : (write_done || read_done) ? IDLE : state;
  fifo_sync #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(push),
    .pop(pop),
    .din({req_wsize, req_wdata}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      read_pending <= 1'b0;
      wenable <= 1'b0;
      renable <= 1'b0;
      req_rdone <= 1'b0;
      wsize <= '0;
      wdata <= '0;
      req_rdata <= '0;
      err_overflow <= 1'b0;
    end else begin
      state <= next_state;
      wenable <= pop;
      renable <= start_read;
      req_rdone <= read_done;
      if (req_wenable && !req_wready) err_overflow <= 1'b1;
      if (pop) begin
        wsize <= head.size;
        wdata <= head.data;
      end
      if (read_done) req_rdata <= rdata;
      read_pending <= read_done ? 1'b0 : (read_pending || req_renable);
    end
  end
endmodule

// File: tb/tb_uart_write_queue.sv
// tb_uart_write_queue: directed and random checks of write ordering, read ordering, overflow and reset
module tb_uart_write_queue;
  localparam int DEPTH = 8;
  localparam logic [34:0] RD_EV = {1'b1, 34'h0};
  logic clk = 1'b0;
  logic rstn, req_wenable, req_renable, req_wready, req_rdone, err_overflow;
  logic wenable, wdone, renable, rdone;
  logic [1:0] req_wsize, wsize;
  logic [31:0] req_wdata, req_rdata, wdata, rdata;
  logic [$clog2(DEPTH):0] count;
  int n_assert = 0, n_fail = 0;
  logic [34:0] ev_q[$];
  logic [31:0] rd_q[$];
  logic pw = 1'b0, pr = 1'b0, pd = 1'b0;
  bit auto_w = 1, rand_dly = 0, force_done = 0, w_owed = 0, r_owed = 0;
  int wdly = 0, rdly = 0;
  logic [31:0] rd_val = '0;
  always #5 clk = ~clk;
  uart_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .req_wenable(req_wenable), .req_wsize(req_wsize),
    .req_wdata(req_wdata), .req_wready(req_wready), .req_renable(req_renable),
    .req_rdone(req_rdone), .req_rdata(req_rdata), .count(count),
    .err_overflow(err_overflow), .wenable(wenable), .wsize(wsize), .wdata(wdata),
    .wdone(wdone), .renable(renable), .rdone(rdone), .rdata(rdata)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [34:0] wr_ev(input logic [1:0] s, input logic [31:0] d);
    return {1'b0, s, d};
  endfunction
  // downstream observer: logs every pulse in order and checks they last one cycle
  always @(negedge clk) begin
    if (wenable || renable || req_rdone) chk("single_pulse", {wenable & pw, renable & pr, req_rdone & pd}, 0);
    if (wenable) ev_q.push_back(wr_ev(wsize, wdata));
    if (renable) ev_q.push_back(RD_EV);
    if (req_rdone) rd_q.push_back(req_rdata);
    pw = wenable;
    pr = renable;
    pd = req_rdone;
  end
  // byte-buffer responder: answers each wenable/renable with wdone/rdone after a delay
  task automatic step();
    @(negedge clk);
    wdone = force_done;
    rdone = force_done;
    if (wenable) begin w_owed = 1; wdly = rand_dly ? int'($urandom_range(0, 5)) : 0; end
    if (renable) begin r_owed = 1; rdly = rand_dly ? int'($urandom_range(0, 5)) : 0; end
    if (w_owed && auto_w) begin
      if (wdly == 0) begin wdone = 1'b1; w_owed = 0; end else wdly--;
    end
    if (r_owed) begin
      if (rdly == 0) begin rdone = 1'b1; rdata = rd_val; r_owed = 0; end else rdly--;
    end
  endtask
  task automatic chk_events(input string tag, input int base, input logic [34:0] exp[$]);
    chk({tag, "_n"}, 64'(ev_q.size() - base), 64'(exp.size()));
    foreach (exp[i]) chk(tag, (base + i < ev_q.size()) ? ev_q[base + i] : 35'hx, exp[i]);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_pulses"}, {wenable, renable, req_rdone}, 0);
    chk({tag, "_wsize"}, wsize, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_rdata"}, req_rdata, 0);
    chk({tag, "_ovf"}, err_overflow, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_wready"}, req_wready, 1);
  endtask
  initial begin
    logic [34:0] exp[$];
    logic [1:0] s;
    logic [31:0] d;
    int base, rbase, t;
    rstn = 1'b0; req_wenable = 0; req_renable = 0; req_wsize = 0; req_wdata = 0;
    wdone = 0; rdone = 0; rdata = 0;
    repeat (2) step();
    chk_zero("reset");
    rstn = 1'b1;
    repeat (2) step();
    chk("post_rst_quiet", {wenable, renable, req_rdone, count}, 0);
    // single write into empty queue
    base = ev_q.size();
    req_wenable = 1; req_wsize = 2'd3; req_wdata = 32'hA1B2C3D4;
    step();
    req_wenable = 0;
    chk("t1_count1", count, 1);
    chk("t1_wen_early", wenable, 0);
    step();
    chk("t1_wen", wenable, 1);
    chk("t1_wdata", wdata, 32'hA1B2C3D4);
    chk("t1_wsize", wsize, 3);
    chk("t1_count0", count, 0);
    step();
    chk("t1_wen_low", wenable, 0);
    // stray done strobes while idle must do nothing
    force_done = 1;
    repeat (3) step();
    force_done = 0;
    rbase = rd_q.size();
    repeat (2) step();
    exp = '{wr_ev(2'd3, 32'hA1B2C3D4)};
    chk_events("t1_events", base, exp);
    chk("stray_rdone", 64'(rd_q.size() - rbase), 0);
    // fill to full with wdone held low; the first entry is already out in WRITE_WAIT
    base = ev_q.size();
    exp.delete();
    auto_w = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      s = 2'($urandom_range(0, 3)); d = $urandom;
      req_wenable = 1; req_wsize = s; req_wdata = d;
      exp.push_back(wr_ev(s, d));
      step();
    end
    chk("t2_full_count", count, DEPTH);
    chk("t2_full_wready", req_wready, 0);
    chk("t2_no_ovf_yet", err_overflow, 0);
    req_wdata = 32'hDEADBEEF;
    step();
    req_wenable = 0;
    chk("t2_ovf", err_overflow, 1);
    chk("t2_ovf_count", count, DEPTH);
    auto_w = 1;
    repeat (40) step();
    chk_events("t2_drain", base, exp);
    chk("t2_count0", count, 0);
    chk("t2_ovf_sticky", err_overflow, 1);
    rstn = 0;
    repeat (2) step();
    w_owed = 0; r_owed = 0;
    rstn = 1;
    step();
    chk("t2_ovf_cleared", err_overflow, 0);
    // two writes then a read (second req_renable ignored)
    base = ev_q.size(); rbase = rd_q.size();
    rd_val = 32'h00000041;
    req_wenable = 1; req_wsize = 2'd1; req_wdata = 32'h11223344;
    step();
    req_wsize = 2'd2; req_wdata = 32'h55667788;
    step();
    req_wenable = 0; req_renable = 1;
    step();
    chk("t3_wready_pending", req_wready, 0);
    step();
    req_renable = 0;
    repeat (20) step();
    exp = '{wr_ev(2'd1, 32'h11223344), wr_ev(2'd2, 32'h55667788), RD_EV};
    chk_events("t3_order", base, exp);
    chk("t3_rdone_n", 64'(rd_q.size() - rbase), 1);
    chk("t3_rdata", req_rdata, 32'h41);
    chk("t3_wready", req_wready, 1);
    chk("t3_no_ovf", err_overflow, 0);
    // same-cycle write and read request
    base = ev_q.size(); rbase = rd_q.size();
    rd_val = 32'h000000A5;
    req_wenable = 1; req_wsize = 2'd0; req_wdata = 32'h55000000; req_renable = 1;
    step();
    req_wenable = 0; req_renable = 0;
    chk("t4_wready0", req_wready, 0);
    step();
    chk("t4_wready_during_write", req_wready, 0);
    repeat (15) step();
    exp = '{wr_ev(2'd0, 32'h55000000), RD_EV};
    chk_events("t4_order", base, exp);
    chk("t4_rdone_data", (rbase < rd_q.size()) ? rd_q[rbase] : 32'hx, 32'hA5);
    chk("t4_wready1", req_wready, 1);
    // reset in the middle of a write with three entries still queued
    auto_w = 0;
    for (int i = 0; i < 4; i++) begin
      req_wenable = 1; req_wsize = 2'd3; req_wdata = 32'hC0DE0000 + i;
      step();
    end
    req_wenable = 0;
    step();
    chk("t5_count3", count, 3);
    #2 rstn = 0;
    #1 chk_zero("t5_async");
    repeat (2) step();
    w_owed = 0; r_owed = 0;
    rstn = 1;
    auto_w = 1;
    base = ev_q.size();
    repeat (10) step();
    chk("t5_no_pulses", 64'(ev_q.size() - base), 0);
    chk("t5_count0", count, 0);
    // random wrap test: 20 writes with random gaps and wdone delays
    base = ev_q.size();
    exp.delete();
    rand_dly = 1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) step();
      t = 0;
      while (!req_wready && t < 50) begin step(); t++; end
      chk("t6_ready_timeout", t < 50, 1);
      s = 2'($urandom_range(0, 3)); d = $urandom;
      req_wenable = 1; req_wsize = s; req_wdata = d;
      exp.push_back(wr_ev(s, d));
      step();
      req_wenable = 0;
    end
    repeat (250) step();
    chk_events("t6_stream", base, exp);
    chk("t6_count0", count, 0);
    chk("t6_no_ovf", err_overflow, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
